// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// registers the fetched word into IF/ID with delay-slot, stall, redirect and AdEL handling.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_exc,
  output logic [4:0]  id_exccode
);

  localparam logic [4:0]  EXC_ADEL = 5'd4;
  // Upper bound carried in 33 bits so a memory ending at 2^32 does not wrap to 0.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc8_q, id_pc8_d;
  logic        id_valid_q, id_valid_d;
  logic        id_exc_q, id_exc_d;
  logic [4:0]  id_exccode_q, id_exccode_d;
  logic        fetch_bad;

  always_comb begin
    fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_END);

    pc_d         = pc_q + 32'd4;
    id_instr_d   = fetch_bad ? 32'h0 : imem_data;
    id_pc_d      = pc_q;
    id_pc8_d     = pc_q + 32'd8;
    id_valid_d   = 1'b1;
    id_exc_d     = fetch_bad;
    id_exccode_d = fetch_bad ? EXC_ADEL : 5'd0;

    if (exc_redirect) begin
      pc_d         = exc_target;
      id_instr_d   = 32'h0;
      id_pc_d      = 32'h0;
      id_pc8_d     = 32'h0;
      id_valid_d   = 1'b0;
      id_exc_d     = 1'b0;
      id_exccode_d = 5'd0;
    end else if (stall) begin
      // Branch is dropped here; ID keeps br_redirect asserted until the stall clears.
      pc_d         = pc_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_pc8_d     = id_pc8_q;
      id_valid_d   = id_valid_q;
      id_exc_d     = id_exc_q;
      id_exccode_d = id_exccode_q;
    end else if (br_redirect) begin
      // IF/ID is not flushed: the word fetched now is the delay slot.
      pc_d = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      id_instr_q   <= 32'h0;
      id_pc_q      <= 32'h0;
      id_pc8_q     <= 32'h0;
      id_valid_q   <= 1'b0;
      id_exc_q     <= 1'b0;
      id_exccode_q <= 5'd0;
    end else begin
      pc_q         <= pc_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc8_q     <= id_pc8_d;
      id_valid_q   <= id_valid_d;
      id_exc_q     <= id_exc_d;
      id_exccode_q <= id_exccode_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign id_instr   = id_instr_q;
  assign id_pc      = id_pc_q;
  assign id_pc8     = id_pc8_q;
  assign id_valid   = id_valid_q;
  assign id_exc     = id_exc_q;
  assign id_exccode = id_exccode_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small combinational memory model and hand-computed
// expectations for PC sequencing, stall, delay slot, redirects, AdEL and reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, br_redirect, exc_redirect;
  logic [31:0] br_target, exc_target;
  logic [31:0] imem_addr, imem_data, pc;
  logic [31:0] id_instr, id_pc, id_pc8;
  logic        id_valid, id_exc;
  logic [4:0]  id_exccode;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_3000: mem = 32'h2401_0001;
      32'h0000_3004: mem = 32'h2402_0002;
      32'h0000_3008: mem = 32'h0022_1820;
      default:       mem = {a[15:0], ~a[15:0]};
    endcase
  endfunction

  assign imem_data = mem(imem_addr);

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_redirect(br_redirect), .br_target(br_target),
    .exc_redirect(exc_redirect), .exc_target(exc_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8),
    .id_valid(id_valid), .id_exc(id_exc), .id_exccode(id_exccode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full expected state; instr is derived from the memory model unless the entry is invalid or faulting.
  task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_id_pc,
                              input logic e_valid, input logic e_exc);
    logic [31:0] e_instr;
    logic [31:0] e_pc8;
    e_instr = (e_valid && !e_exc) ? mem(e_id_pc) : 32'h0;
    e_pc8   = e_valid ? e_id_pc + 32'd8 : 32'h0;
    chk({tag, ".pc"},        pc,        e_pc);
    chk({tag, ".imem_addr"}, imem_addr, e_pc);
    chk({tag, ".id_pc"},     id_pc,     e_id_pc);
    chk({tag, ".id_pc8"},    id_pc8,    e_pc8);
    chk({tag, ".id_instr"},  id_instr,  e_instr);
    chk({tag, ".id_valid"},  32'(id_valid), 32'(e_valid));
    chk({tag, ".id_exc"},    32'(id_exc),   32'(e_exc));
    chk({tag, ".exccode"},   32'(id_exccode), e_exc ? 32'd4 : 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_redirect = 1'b0; exc_redirect = 1'b0;
    br_target = 32'h0; exc_target = 32'h0;
    step(); step();
    expect_state("reset", 32'h3000, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    step(); expect_state("run1", 32'h3004, 32'h3000, 1'b1, 1'b0);
    chk("run1.word", id_instr, 32'h2401_0001);
    step(); expect_state("run2", 32'h3008, 32'h3004, 1'b1, 1'b0);
    chk("run2.word", id_instr, 32'h2402_0002);

    stall = 1'b1;
    step(); expect_state("stall1", 32'h3008, 32'h3004, 1'b1, 1'b0);
    step(); expect_state("stall2", 32'h3008, 32'h3004, 1'b1, 1'b0);
    stall = 1'b0;
    step(); expect_state("release", 32'h300C, 32'h3008, 1'b1, 1'b0);
    chk("release.word", id_instr, 32'h0022_1820);
    step(); expect_state("run4", 32'h3010, 32'h300C, 1'b1, 1'b0);
    step(); expect_state("run5", 32'h3014, 32'h3010, 1'b1, 1'b0);

    br_redirect = 1'b1; br_target = 32'h3040;
    step(); expect_state("dslot", 32'h3040, 32'h3014, 1'b1, 1'b0);
    br_redirect = 1'b0;
    step(); expect_state("target", 32'h3044, 32'h3040, 1'b1, 1'b0);

    stall = 1'b1; br_redirect = 1'b1; br_target = 32'h3080;
    step(); expect_state("br_stall", 32'h3044, 32'h3040, 1'b1, 1'b0);
    stall = 1'b0;
    step(); expect_state("br_after", 32'h3080, 32'h3044, 1'b1, 1'b0);
    br_redirect = 1'b0;
    step(); expect_state("br_tgt2", 32'h3084, 32'h3080, 1'b1, 1'b0);

    br_redirect = 1'b1; br_target = 32'h3042;
    step(); expect_state("mis_br", 32'h3042, 32'h3084, 1'b1, 1'b0);
    br_redirect = 1'b0;
    step(); expect_state("mis_adel", 32'h3046, 32'h3042, 1'b1, 1'b1);

    exc_redirect = 1'b1; exc_target = 32'h4180;
    br_redirect = 1'b1; br_target = 32'h5000; stall = 1'b1;
    step(); expect_state("exc", 32'h4180, 32'h0, 1'b0, 1'b0);
    exc_redirect = 1'b0; br_redirect = 1'b0; stall = 1'b0;
    step(); expect_state("handler", 32'h4184, 32'h4180, 1'b1, 1'b0);

    br_redirect = 1'b1; br_target = 32'h2FFC;
    step(); expect_state("low_br", 32'h2FFC, 32'h4184, 1'b1, 1'b0);
    br_redirect = 1'b0;
    step(); expect_state("low_adel", 32'h3000, 32'h2FFC, 1'b1, 1'b1);

    br_redirect = 1'b1; br_target = 32'h7000;
    step(); expect_state("hi_br", 32'h7000, 32'h3000, 1'b1, 1'b0);
    br_redirect = 1'b1; br_target = 32'h6FFC;
    step(); expect_state("hi_adel", 32'h6FFC, 32'h7000, 1'b1, 1'b1);
    br_redirect = 1'b0;
    step(); expect_state("last_ok", 32'h7000, 32'h6FFC, 1'b1, 1'b0);

    br_redirect = 1'b1; br_target = 32'hFFFF_FFFC;
    step(); expect_state("wrap_br", 32'hFFFF_FFFC, 32'h7000, 1'b1, 1'b1);
    br_redirect = 1'b0;
    step(); expect_state("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b1);

    reset = 1'b1; stall = 1'b1; br_redirect = 1'b1; br_target = 32'h3040;
    step(); expect_state("midreset", 32'h3000, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; stall = 1'b0; br_redirect = 1'b0;
    step(); expect_state("post_reset", 32'h3004, 32'h3000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core: owns the PC, drives the instruction memory address, and registers the returned word into the IF/ID pipeline register.
- Sits between the CP0/hazard/branch logic (upstream control) and the instruction memory and ID stage (downstream).
- Implements MIPS branch-delay-slot semantics, stall hold, exception redirect and fetch-address exception detection (AdEL).

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_WORDS, 4096, instruction memory depth in words; legal range is IM_BASE to IM_BASE+4*IM_WORDS-1

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
br_redirect  in  1  branch/jump taken, resolved in ID
br_target  in  32  branch/jump target
exc_redirect  in  1  CP0 exception or eret: redirect and flush
exc_target  in  32  handler or EPC address
imem_addr  out  32  fetch address to instruction memory (equals pc)
imem_data  in  32  instruction word from memory, combinational on imem_addr
pc  out  32  current fetch PC
id_instr  out  32  IF/ID instruction
id_pc  out  32  IF/ID PC
id_pc8  out  32  IF/ID PC+8 (link value)
id_valid  out  1  IF/ID holds a real fetched instruction
id_exc  out  1  fetch exception flagged on this instruction
id_exccode  out  5  5'd4 (AdEL) when id_exc is set, else 0

Behaviour:
- imem_addr = pc, combinational. No other combinational path from inputs to outputs.
- fetch_bad = (pc[1:0] != 0) | (pc < IM_BASE) | (pc >= IM_BASE + 4*IM_WORDS). Compare as unsigned 32-bit. The upper bound is computed in 33 bits to avoid wrap.
- Next-PC priority at posedge, highest first:
  1. reset -> RESET_PC
  2. exc_redirect -> exc_target; overrides stall
  3. stall -> hold pc; br_redirect is ignored this cycle. The ID stage re-asserts br_redirect until stall drops.
  4. br_redirect -> br_target
  5. otherwise pc + 4, wrapping modulo 2^32
- IF/ID update at posedge, same priority order:
  - reset or exc_redirect: id_instr=0, id_pc=0, id_pc8=0, id_valid=0, id_exc=0, id_exccode=0.
  - stall: all IF/ID outputs hold.
  - otherwise: id_pc=pc, id_pc8=pc+8, id_valid=1, id_exc=fetch_bad, id_exccode=fetch_bad?4:0, id_instr=fetch_bad?32'h0:imem_data.
- Delay slot: br_redirect does not flush IF/ID. The word fetched in the redirect cycle (pc+4 of the branch) is captured normally as the delay slot.
- A misaligned or out-of-range PC does not stop fetch. The PC keeps advancing until CP0 asserts exc_redirect.
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, all id_* outputs 0.
- Reset mid-stall or mid-redirect: reset wins; the first fetch after reset deasserts is RESET_PC.
- Simultaneous exc_redirect and br_redirect: exception wins; the branch is discarded.
- Simultaneous exc_redirect and stall: redirect and flush still occur.

Test Plan:
- Reset then 3 free-running cycles, memory words at 0x3000/0x3004/0x3008 = 0x24010001/0x24020002/0x00221820. Required: pc goes 0x3000->0x3004->0x3008->0x300C; id_instr follows one cycle behind; id_pc8 = id_pc+8; id_valid=1 from the first capture.
- Stall held 2 cycles at pc=0x3008. Required: pc and all id_* outputs frozen for both cycles; on release pc=0x300C and id_pc=0x3008.
- Branch at id_pc=0x3010 asserts br_redirect with br_target=0x3040. Required: delay slot 0x3014 captured with id_valid=1; the next capture has id_pc=0x3040.
- br_redirect with stall in the same cycle, br_redirect held 1 more cycle after stall drops. Required: pc holds during the stall, then becomes br_target.
- br_target=0x3042 (misaligned). Required: next IF/ID shows id_exc=1, id_exccode=4, id_instr=0. Then exc_redirect to 0x4180: IF/ID cleared (id_valid=0) and pc=0x4180.
- Out-of-range fetch at pc=0x2FFC and at pc=0x7000. Required: both flagged AdEL. Reset asserted mid-run: pc=0x3000 and all id_* outputs 0 on the next edge.
